// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default timing constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // 100 MHz clock, 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial line in, parallel byte and status out
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  // receiver side
  modport master (
    input  rx_in,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  // pad driver / byte consumer side
  modport slave (
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - bit-period counter with half and full bit ticks
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  localparam int HALF_BIT     = CLKS_PER_BIT / 2,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);

  logic [CNT_W-1:0] cnt;

  // count enabled cycles; clear has priority so every state entry starts at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
  assign full_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: sync, start detect, bit sampling, framing
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_ctrl_if.master  bus
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  rx_state_e            state;
  rx_state_e            state_nx;
  logic                 s1;
  logic                 rx_s;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 half_tick;
  logic                 full_tick;
  logic                 bit_take;
  logic                 frame_ok;
  logic                 frame_bad;

  // two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= bus.rx_in;
      rx_s <= s1;
    end
  end

  uart_rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // next-state and per-cycle control decisions
  always_comb begin
    state_nx  = state;
    cnt_en    = 1'b0;
    bit_take  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_nx = START;
      end
      START: begin
        cnt_en = 1'b1;
        // line back high at mid start bit means it was a glitch
        if (half_tick) state_nx = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (full_tick) begin
          bit_take = 1'b1;
          if (idx == IDX_W'(DATA_BITS - 1)) state_nx = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (full_tick) begin
          if (rx_s) begin
            frame_ok = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // a held-low line must not be taken as a new start bit
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // counter restarts on every state change and after each data sample
  assign cnt_clr = (state_nx != state) || bit_take;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // shift register, bit index and registered output strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      shreg         <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_valid  <= frame_ok;
      bus.frame_err <= frame_bad;
      if (state == START && state_nx == DATA) begin
        idx <= '0;
      end else if (bit_take) begin
        idx <= idx + 1'b1;
      end
      // first bit on the line is shifted furthest, ending up in bit 0
      if (bit_take) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (frame_ok) bus.rx_data <= shreg;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule
